// File: rtl/cache_controller_if.sv
// ----------------------------------------------------------------------------
// cache_controller_if : CPU load port, cache port and memory port bundle
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface cache_controller_if;
  logic         cpu_rd;
  logic [14:0]  cpu_addr;
  logic [31:0]  cpu_data;
  logic         cpu_ready;
  logic [14:0]  cache_address;
  logic         cache_wrEn;
  logic [127:0] cache_inData;
  logic [31:0]  cache_outData;
  logic         cache_hit;
  logic         mem_rd;
  logic [14:0]  mem_addr;
  logic [31:0]  mem_data;
  logic         mem_ready;

  // environment view: CPU, cache array and memory models
  modport master (
    output cpu_rd, cpu_addr, cache_outData, cache_hit, mem_data, mem_ready,
    input  cpu_data, cpu_ready, cache_address, cache_wrEn, cache_inData,
           mem_rd, mem_addr
  );

  // controller view
  modport slave (
    input  cpu_rd, cpu_addr, cache_outData, cache_hit, mem_data, mem_ready,
    output cpu_data, cpu_ready, cache_address, cache_wrEn, cache_inData,
           mem_rd, mem_addr
  );
endinterface

`default_nettype wire

// File: rtl/cache_controller.sv
// ----------------------------------------------------------------------------
// cache_controller : read sequencer for a direct-mapped cache with line refill
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cache_controller #(
  parameter int COUNT_W = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  cache_controller_if.slave       bus,
  output logic [COUNT_W-1:0]      hit_count,
  output logic [COUNT_W-1:0]      miss_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [COUNT_W-1:0] c_count_one = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next;
  logic [14:0]   r_req_addr;
  logic [1:0]    r_cnt;
  logic [127:0]  r_buffer;
  logic [31:0]   r_cpu_data;
  logic [COUNT_W-1:0] r_hit_count;
  logic [COUNT_W-1:0] r_miss_count;
  logic [31:0]   w_sel_word;
  logic          w_cpu_ready;
  logic          w_wr_en;
  logic          w_mem_rd;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cpu_ready = 1'b0;
    w_wr_en     = 1'b0;
    w_mem_rd    = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.cpu_rd) w_next = S_LOOKUP;
      S_LOOKUP: w_next = bus.cache_hit ? S_DONE : S_FILL;
      S_FILL: begin
        w_mem_rd = 1'b1;
        if (bus.mem_ready && (r_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_wr_en = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_cpu_ready = 1'b1;
        w_next      = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // word 0 of the line sits in the most significant slot
  always_comb begin
    case (r_req_addr[1:0])
      2'd0:    w_sel_word = r_buffer[127:96];
      2'd1:    w_sel_word = r_buffer[95:64];
      2'd2:    w_sel_word = r_buffer[63:32];
      default: w_sel_word = r_buffer[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr   <= '0;
      r_cnt        <= '0;
      r_buffer     <= '0;
      r_cpu_data   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.cpu_rd) r_req_addr <= bus.cpu_addr;
        S_LOOKUP: begin
          if (bus.cache_hit) begin
            r_cpu_data <= bus.cache_outData;
            if (r_hit_count != '1) r_hit_count <= r_hit_count + c_count_one;
          end else begin
            r_cnt <= 2'd0;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + c_count_one;
          end
        end
        S_FILL: begin
          if (bus.mem_ready) begin
            case (r_cnt)
              2'd0:    r_buffer[127:96] <= bus.mem_data;
              2'd1:    r_buffer[95:64]  <= bus.mem_data;
              2'd2:    r_buffer[63:32]  <= bus.mem_data;
              default: r_buffer[31:0]   <= bus.mem_data;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_WRITE: r_cpu_data <= w_sel_word;
        default: ;
      endcase
    end
  end

  assign bus.cpu_data      = r_cpu_data;
  assign bus.cpu_ready     = w_cpu_ready;
  assign bus.cache_address = r_req_addr;
  assign bus.cache_wrEn    = w_wr_en;
  assign bus.cache_inData  = r_buffer;
  assign bus.mem_rd        = w_mem_rd;
  assign bus.mem_addr      = {r_req_addr[14:2], r_cnt};
  assign hit_count         = r_hit_count;
  assign miss_count        = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ----------------------------------------------------------------------------
// tb_cache_controller : directed tests with cache array and memory models
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cache_controller;

  localparam int TB_COUNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic [TB_COUNT_W-1:0] hit_count, miss_count;
  cache_controller_if bus();

  always #5 clk = ~clk;

  cache_controller #(.COUNT_W(TB_COUNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // cache array model
  logic [127:0] c_data  [1024];
  logic [2:0]   c_tag   [1024];
  logic         c_valid [1024];
  logic         clear_req;
  logic [127:0] w_line;

  always @(posedge clk) begin
    if (clear_req) begin
      for (int i = 0; i < 1024; i++) c_valid[i] <= 1'b0;
    end else if (bus.cache_wrEn) begin
      c_valid[bus.cache_address[11:2]] <= 1'b1;
      c_tag[bus.cache_address[11:2]]   <= bus.cache_address[14:12];
      c_data[bus.cache_address[11:2]]  <= bus.cache_inData;
    end
  end

  assign bus.cache_hit = c_valid[bus.cache_address[11:2]] &&
                         (c_tag[bus.cache_address[11:2]] == bus.cache_address[14:12]);
  assign w_line = c_data[bus.cache_address[11:2]];
  always_comb begin
    case (bus.cache_address[1:0])
      2'd0:    bus.cache_outData = w_line[127:96];
      2'd1:    bus.cache_outData = w_line[95:64];
      2'd2:    bus.cache_outData = w_line[63:32];
      default: bus.cache_outData = w_line[31:0];
    endcase
  end

  // memory model: word = {tag, index^1, offset} pattern plus one
  int wait_n;
  int wcnt;
  function automatic logic [31:0] mem_word(input logic [14:0] a);
    logic [31:0] w;
    w = {1'b0, a[14:12], 10'h000, a[11:2] ^ 10'd1, 6'h00, a[1:0]};
    return w + 32'd1;
  endfunction

  always @(posedge clk) begin
    if (!bus.mem_rd || bus.mem_ready) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end
  assign bus.mem_ready = bus.mem_rd && (wcnt == wait_n);
  assign bus.mem_data  = mem_word(bus.mem_addr);

  int n_cmp = 0;
  int n_fail = 0;

  // observations gathered by collect()
  int           acc_n, wr_n, wr_k, rdy_k, memrd_n, hold_err;
  logic [14:0]  acc_addr [16];
  logic [127:0] wr_line;
  logic [31:0]  rdy_data;

  task automatic restart();
    @(negedge clk); rst = 1'b1; clear_req = 1'b1;
    @(negedge clk); rst = 1'b0; clear_req = 1'b0;
  endtask

  task automatic issue(input logic [14:0] a);
    @(negedge clk); bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    @(posedge clk); #1; bus.cpu_rd = 1'b0;
  endtask

  // k counts edges after the accepting edge; ends one cycle after cpu_ready
  task automatic collect();
    logic        pend;
    logic [14:0] prev;
    acc_n = 0; wr_n = 0; wr_k = -1; rdy_k = -1; memrd_n = 0; hold_err = 0;
    rdy_data = '0; wr_line = '0; pend = 1'b0; prev = '0;
    for (int k = 0; k < 60; k++) begin
      if (bus.mem_rd) begin
        memrd_n++;
        if (pend && bus.mem_addr !== prev) hold_err++;
        if (bus.mem_ready) begin
          if (acc_n < 16) acc_addr[acc_n] = bus.mem_addr;
          acc_n++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          prev = bus.mem_addr;
        end
      end
      if (bus.cache_wrEn) begin wr_n++; wr_k = k; wr_line = bus.cache_inData; end
      if (bus.cpu_ready) begin rdy_k = k; rdy_data = bus.cpu_data; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", bus.cpu_ready); end
    n_cmp++; if (bus.cpu_data !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_data: got %h want 0", bus.cpu_data); end
    n_cmp++; if (bus.cache_wrEn !== 1'b0) begin n_fail++; $display("FAIL reset_wrEn: got %b want 0", bus.cache_wrEn); end
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
    n_cmp++; if (bus.cache_address !== 15'h0) begin n_fail++; $display("FAIL reset_cache_address: got %h want 0", bus.cache_address); end
    n_cmp++; if (bus.mem_addr !== 15'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.cache_inData !== 128'h0) begin n_fail++; $display("FAIL reset_inData: got %h want 0", bus.cache_inData); end
    n_cmp++; if ({hit_count, miss_count} !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
  endtask

  task automatic test_cold_miss();
    restart();
    issue(15'h1005);
    collect();
    n_cmp++; if (acc_n !== 4) begin n_fail++; $display("FAIL cold_accepts: got %0d want 4", acc_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (acc_addr[i] !== 15'h1004 + 15'(i)) begin n_fail++; $display("FAIL cold_mem_addr[%0d]: got %h want %h", i, acc_addr[i], 15'h1004 + 15'(i)); end
    end
    n_cmp++; if (wr_n !== 1 || wr_k !== 5) begin n_fail++; $display("FAIL cold_wrEn: got %0d writes at k=%0d want 1 at k=5", wr_n, wr_k); end
    n_cmp++; if (wr_line !== 128'h10000001_10000002_10000003_10000004) begin n_fail++; $display("FAIL cold_line: got %h want 10000001100000021000000310000004", wr_line); end
    n_cmp++; if (rdy_k !== 6) begin n_fail++; $display("FAIL cold_ready_k: got %0d want 6", rdy_k); end
    n_cmp++; if (rdy_data !== 32'h10000002) begin n_fail++; $display("FAIL cold_data: got %h want 10000002", rdy_data); end
    n_cmp++; if (miss_count !== 2'd1 || hit_count !== 2'd0) begin n_fail++; $display("FAIL cold_counts: got h%0d/m%0d want h0/m1", hit_count, miss_count); end
  endtask

  task automatic test_hit_after_fill();
    issue(15'h1007);
    collect();
    n_cmp++; if (memrd_n !== 0) begin n_fail++; $display("FAIL hit_mem_rd: got %0d cycles want 0", memrd_n); end
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL hit_wrEn: got %0d want 0", wr_n); end
    n_cmp++; if (rdy_k !== 1) begin n_fail++; $display("FAIL hit_ready_k: got %0d want 1", rdy_k); end
    n_cmp++; if (rdy_data !== 32'h10000004) begin n_fail++; $display("FAIL hit_data: got %h want 10000004", rdy_data); end
    n_cmp++; if (hit_count !== 2'd1 || miss_count !== 2'd1) begin n_fail++; $display("FAIL hit_counts: got h%0d/m%0d want h1/m1", hit_count, miss_count); end
  endtask

  task automatic test_wait_states();
    restart();
    wait_n = 2;
    issue(15'h1006);
    collect();
    wait_n = 0;
    n_cmp++; if (acc_n !== 4 || acc_addr[0] !== 15'h1004 || acc_addr[3] !== 15'h1007) begin n_fail++; $display("FAIL wait_accepts: got %0d first %h last %h want 4 1004 1007", acc_n, acc_addr[0], acc_addr[3]); end
    n_cmp++; if (hold_err !== 0) begin n_fail++; $display("FAIL wait_addr_hold: got %0d changes want 0", hold_err); end
    n_cmp++; if (memrd_n !== 12) begin n_fail++; $display("FAIL wait_fill_cycles: got %0d want 12", memrd_n); end
    n_cmp++; if (wr_k !== 13 || rdy_k !== 14) begin n_fail++; $display("FAIL wait_timing: got wr %0d ready %0d want 13 14", wr_k, rdy_k); end
    n_cmp++; if (rdy_data !== 32'h10000003) begin n_fail++; $display("FAIL wait_data: got %h want 10000003", rdy_data); end
  endtask

  task automatic test_conflict();
    restart();
    issue(15'h1005); collect();
    issue(15'h2005); collect();
    n_cmp++; if (acc_n !== 4 || acc_addr[0] !== 15'h2004 || acc_addr[3] !== 15'h2007) begin n_fail++; $display("FAIL conflict_refill: got %0d first %h last %h want 4 2004 2007", acc_n, acc_addr[0], acc_addr[3]); end
    n_cmp++; if (rdy_k !== 6 || rdy_data !== 32'h20000002) begin n_fail++; $display("FAIL conflict_data: got k%0d %h want k6 20000002", rdy_k, rdy_data); end
    issue(15'h1005); collect();
    n_cmp++; if (acc_n !== 4 || rdy_data !== 32'h10000002) begin n_fail++; $display("FAIL conflict_remiss: got %0d accepts data %h want 4 10000002", acc_n, rdy_data); end
    n_cmp++; if (miss_count !== 2'd3 || hit_count !== 2'd0) begin n_fail++; $display("FAIL conflict_counts: got h%0d/m%0d want h0/m3", hit_count, miss_count); end
  endtask

  task automatic test_reset_mid_fill();
    int got, bad;
    restart();
    issue(15'h1005);
    got = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      if (bus.mem_rd && bus.mem_ready) got++;
      @(posedge clk); #1;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.mem_rd !== 1'b0 || bus.cache_wrEn !== 1'b0 || bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got rd%b wr%b rdy%b want 000", bus.mem_rd, bus.cache_wrEn, bus.cpu_ready); end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.mem_rd || bus.cache_wrEn || bus.cpu_ready) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles want 0", bad); end
    issue(15'h1005);
    collect();
    n_cmp++; if (acc_n !== 4 || acc_addr[0] !== 15'h1004 || acc_addr[3] !== 15'h1007) begin n_fail++; $display("FAIL midreset_refetch: got %0d first %h last %h want 4 1004 1007", acc_n, acc_addr[0], acc_addr[3]); end
    n_cmp++; if (rdy_data !== 32'h10000002 || miss_count !== 2'd1) begin n_fail++; $display("FAIL midreset_result: got %h m%0d want 10000002 m1", rdy_data, miss_count); end
  endtask

  task automatic test_back_to_back();
    int pulses, cyc, bad, rd;
    int stamp [5];
    restart();
    issue(15'h1005); collect();
    @(negedge clk); bus.cpu_rd = 1'b1; bus.cpu_addr = 15'h1005;
    pulses = 0; cyc = 0; bad = 0; rd = 0;
    while (pulses < 5 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (bus.mem_rd) rd++;
      if (bus.cpu_ready) begin
        stamp[pulses] = cyc;
        if (bus.cpu_data !== 32'h10000002) bad++;
        pulses++;
      end
    end
    bus.cpu_rd = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (pulses !== 5) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 5", pulses); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (i < pulses && stamp[i] !== 2 + 3 * i) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got cycle %0d want %0d", i, stamp[i], 2 + 3 * i); end
    end
    n_cmp++; if (bad !== 0 || rd !== 0) begin n_fail++; $display("FAIL b2b_hits: got %0d bad data %0d mem cycles want 0 0", bad, rd); end
    n_cmp++; if (hit_count !== 2'd3 || miss_count !== 2'd1) begin n_fail++; $display("FAIL b2b_saturate: got h%0d/m%0d want h3/m1", hit_count, miss_count); end
  endtask

  initial begin
    rst = 1'b1; clear_req = 1'b1; wait_n = 0;
    bus.cpu_rd = 1'b0; bus.cpu_addr = '0;
    repeat (2) @(posedge clk);
    #1; clear_req = 1'b0;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_cold_miss();
    test_hit_after_fill();
    test_wait_states();
    test_conflict();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
